// File: rtl/eth_pattern_gen_if.sv
// eth_pattern_gen_if: AXI-stream style payload bus.
// master drives data/valid/last, slave returns ready.
interface eth_pattern_gen_if #(
  parameter int DATA_SIZE = 16
);
  logic [DATA_SIZE-1:0] axiod;
  logic                 axiov;
  logic                 axiol;
  logic                 axior;

  modport master (
    output axiod, axiov, axiol,
    input  axior
  );

  modport slave (
    input  axiod, axiov, axiol,
    output axior
  );
endinterface

// File: rtl/eth_pattern_gen.sv
// eth_pattern_gen: triggered packet source with TABLE/INCR/LFSR/CONST data.
// Define PATGEN_CHECKSUM_EN to append an XOR checksum word to each packet.
module eth_pattern_gen #(
  parameter int DATA_SIZE = 16,
  parameter int LEN_W     = 8,
  parameter int CNT_W     = 8,
  parameter     SEED      = 16'hABCD,
  parameter     LFSR_TAPS = 16'hB400
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trigger,
  input  logic [1:0]         mode,
  input  logic [LEN_W-1:0]   pkt_len,
  input  logic [CNT_W-1:0]   num_pkts,
  input  logic [LEN_W-1:0]   gap_cycles,
  eth_pattern_gen_if.master  axis,
  output logic               busy,
  output logic [CNT_W-1:0]   pkts_sent
);

  localparam logic [DATA_SIZE-1:0] SEED_W = DATA_SIZE'(SEED);
  localparam logic [DATA_SIZE-1:0] TAPS_W = DATA_SIZE'(LFSR_TAPS);
  localparam logic [DATA_SIZE-1:0] LFSR_INIT =
    (SEED_W == '0) ? DATA_SIZE'(1) : SEED_W;

  localparam logic [DATA_SIZE-1:0] T0 = DATA_SIZE'(16'hABCD);
  localparam logic [DATA_SIZE-1:0] T1 = DATA_SIZE'(16'h6969);
  localparam logic [DATA_SIZE-1:0] T2 = DATA_SIZE'(16'hFFFF);
  localparam logic [DATA_SIZE-1:0] T3 = DATA_SIZE'(16'h0420);

  localparam logic [1:0] M_TABLE = 2'd0;
  localparam logic [1:0] M_INCR  = 2'd1;
  localparam logic [1:0] M_LFSR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  function automatic logic [DATA_SIZE-1:0] lfsr_next(
    input logic [DATA_SIZE-1:0] v
  );
    lfsr_next = (v >> 1) ^ (v[0] ? TAPS_W : '0);
  endfunction

  state_t               state_q, state_d;
  logic                 trig_q, rise_q;
  logic [1:0]           mode_q, tidx_q;
  logic [LEN_W-1:0]     len_q, gap_q, gcnt_q, widx_q;
  logic [CNT_W-1:0]     rem_q, sent_q;
  logic [DATA_SIZE-1:0] val_q, tbl_word, word, tx_word;
  logic                 valid, xfer, last, adv, pkt_end, accept;
  logic                 rem_last;

  always_comb begin
    tbl_word = T0;
    unique case (tidx_q)
      2'd0: tbl_word = T0;
      2'd1: tbl_word = T1;
      2'd2: tbl_word = T2;
      2'd3: tbl_word = T3;
    endcase
  end

  assign word  = (mode_q == M_TABLE) ? tbl_word : val_q;
  assign valid = (state_q == SEND);
  assign xfer  = valid & axis.axior;

`ifdef PATGEN_CHECKSUM_EN
  logic [DATA_SIZE-1:0] acc_q;
  logic                 chk_ph;

  // Index pkt_len is the trailing checksum slot.
  assign chk_ph  = (widx_q == len_q);
  assign last    = chk_ph;
  assign adv     = xfer & ~chk_ph;
  assign tx_word = chk_ph ? acc_q : word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (accept || pkt_end) begin
      acc_q <= '0;
    end else if (adv) begin
      acc_q <= acc_q ^ word;
    end
  end
`else
  assign last    = (widx_q == len_q - LEN_W'(1));
  assign adv     = xfer;
  assign tx_word = word;
`endif

  assign pkt_end  = xfer & last;
  assign rem_last = (rem_q == CNT_W'(1));
  assign accept   = (state_q == IDLE) & rise_q &
                    (|pkt_len) & (|num_pkts);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SEND;
      end
      SEND: begin
        if (pkt_end) begin
          if (rem_last)          state_d = IDLE;
          else if (gap_q != '0)  state_d = GAP;
        end
      end
      GAP: begin
        if (gcnt_q == LEN_W'(1)) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= 1'b0;
      rise_q <= 1'b0;
      mode_q <= M_TABLE;
      len_q  <= '0;
      gap_q  <= '0;
      rem_q  <= '0;
      gcnt_q <= '0;
      widx_q <= '0;
      tidx_q <= '0;
      val_q  <= '0;
      sent_q <= '0;
    end else begin
      trig_q <= trigger;
      rise_q <= trigger & ~trig_q;
      if (accept) begin
        mode_q <= mode;
        len_q  <= pkt_len;
        gap_q  <= gap_cycles;
        rem_q  <= num_pkts;
        widx_q <= '0;
        tidx_q <= '0;
        val_q  <= (mode == M_LFSR) ? LFSR_INIT : SEED_W;
      end
      if (adv) begin
        tidx_q <= tidx_q + 2'd1;
        unique case (1'b1)
          mode_q == M_INCR: val_q <= val_q + DATA_SIZE'(1);
          mode_q == M_LFSR: val_q <= lfsr_next(val_q);
          default:          val_q <= val_q;
        endcase
      end
      if (xfer) begin
        widx_q <= last ? '0 : widx_q + LEN_W'(1);
      end
      if (pkt_end) begin
        sent_q <= sent_q + CNT_W'(1);
        rem_q  <= rem_q - CNT_W'(1);
        gcnt_q <= gap_q;
      end else if (state_q == GAP) begin
        gcnt_q <= gcnt_q - LEN_W'(1);
      end
    end
  end

  assign axis.axiod = valid ? tx_word : '0;
  assign axis.axiov = valid;
  assign axis.axiol = valid & last;
  assign busy       = (state_q != IDLE);
  assign pkts_sent  = sent_q;

endmodule

// File: tb/tb_eth_pattern_gen.sv
// tb_eth_pattern_gen: scoreboard bench for eth_pattern_gen.
// Three instances differ only in SEED; sel picks the one observed.
module tb_eth_pattern_gen;
  localparam int DS = 16;
  localparam int LW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst_n, trigger, rdy;
  logic [1:0]    mode;
  logic [LW-1:0] pkt_len, gap_cycles;
  logic [CW-1:0] num_pkts;
  logic          busy_a, busy_b, busy_c;
  logic [CW-1:0] ps_a, ps_b, ps_c;

  eth_pattern_gen_if #(.DATA_SIZE(DS)) if_a ();
  eth_pattern_gen_if #(.DATA_SIZE(DS)) if_b ();
  eth_pattern_gen_if #(.DATA_SIZE(DS)) if_c ();

  assign if_a.axior = rdy;
  assign if_b.axior = rdy;
  assign if_c.axior = rdy;

  eth_pattern_gen #(.SEED(16'hABCD)) u_a (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .mode(mode),
    .pkt_len(pkt_len), .num_pkts(num_pkts), .gap_cycles(gap_cycles),
    .axis(if_a), .busy(busy_a), .pkts_sent(ps_a)
  );
  eth_pattern_gen #(.SEED(16'hFFFE)) u_b (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .mode(mode),
    .pkt_len(pkt_len), .num_pkts(num_pkts), .gap_cycles(gap_cycles),
    .axis(if_b), .busy(busy_b), .pkts_sent(ps_b)
  );
  eth_pattern_gen #(.SEED(16'h1234)) u_c (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .mode(mode),
    .pkt_len(pkt_len), .num_pkts(num_pkts), .gap_cycles(gap_cycles),
    .axis(if_c), .busy(busy_c), .pkts_sent(ps_c)
  );

  int            sel;
  logic [DS-1:0] m_d;
  logic          m_v, m_l, m_busy;
  logic [CW-1:0] m_ps;

  always_comb begin
    m_d = if_a.axiod; m_v = if_a.axiov; m_l = if_a.axiol;
    m_busy = busy_a; m_ps = ps_a;
    case (sel)
      1: begin
        m_d = if_b.axiod; m_v = if_b.axiov; m_l = if_b.axiol;
        m_busy = busy_b; m_ps = ps_b;
      end
      2: begin
        m_d = if_c.axiod; m_v = if_c.axiov; m_l = if_c.axiol;
        m_busy = busy_c; m_ps = ps_c;
      end
      default: ;
    endcase
  end

  typedef struct packed {
    logic [DS-1:0] d;
    logic          l;
  } exp_t;

  exp_t          q[$];
  int            total, passed, popped, stalls;
  int            gap_run, last_gap, n;
  logic          held_v, held_l;
  logic [DS-1:0] held_d;
  bit            toggle;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic monitor();
    exp_t e;
    if (held_v) begin
      chk("stall_v", 64'(m_v), 64'd1);
      chk("stall_d", 64'(m_d), 64'(held_d));
      chk("stall_l", 64'(m_l), 64'(held_l));
    end
    held_v = 1'b0;
    if (m_v && rdy) begin
      if (q.size() == 0) begin
        total++;
        $error("FAIL extra_word observed=%0h expected=none", m_d);
      end else begin
        e = q.pop_front();
        chk("word_d", 64'(m_d), 64'(e.d));
        chk("word_l", 64'(m_l), 64'(e.l));
        popped++;
      end
    end else if (m_v) begin
      held_v = 1'b1;
      held_d = m_d;
      held_l = m_l;
      stalls++;
    end
    if (m_v) begin
      if (gap_run != 0) last_gap = gap_run;
      gap_run = 0;
    end else if (m_busy) begin
      gap_run++;
    end else begin
      gap_run = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle) rdy = ~rdy;
    @(negedge clk);
    monitor();
  endtask

  function automatic logic [15:0] seed_of(input int s);
    case (s)
      1:       seed_of = 16'hFFFE;
      2:       seed_of = 16'h1234;
      default: seed_of = 16'hABCD;
    endcase
  endfunction

  task automatic push_run(input logic [1:0] md, input int len,
                          input int np, input logic [15:0] seed);
    logic [15:0] tbl [4];
    logic [15:0] v, acc, wd;
    int          t;
    exp_t        e;
    tbl[0] = 16'hABCD; tbl[1] = 16'h6969;
    tbl[2] = 16'hFFFF; tbl[3] = 16'h0420;
    v = (md == 2'd2 && seed == 16'h0) ? 16'h1 : seed;
    t = 0;
    for (int p = 0; p < np; p++) begin
      acc = 16'h0;
      for (int w = 0; w < len; w++) begin
        wd = (md == 2'd0) ? tbl[t] : v;
        e.d = wd;
`ifdef PATGEN_CHECKSUM_EN
        e.l = 1'b0;
`else
        e.l = (w == len - 1);
`endif
        q.push_back(e);
        acc = acc ^ wd;
        t = (t + 1) % 4;
        if (md == 2'd1) v = v + 16'h1;
        if (md == 2'd2) v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0);
      end
`ifdef PATGEN_CHECKSUM_EN
      e.d = acc;
      e.l = 1'b1;
      q.push_back(e);
`endif
    end
  endtask

  task automatic start(input int s, input logic [1:0] md, input int len,
                       input int np, input int gap, input bit hold);
    sel        = s;
    mode       = md;
    pkt_len    = LW'(len);
    num_pkts   = CW'(np);
    gap_cycles = LW'(gap);
    push_run(md, len, np, seed_of(s));
    trigger = 1'b1;
    tick();
    if (!hold) trigger = 1'b0;
    chk("lat_edge1", 64'(m_v), 64'd0);
    tick();
    chk("lat_edge2", 64'(m_v), 64'd1);
  endtask

  task automatic wait_idle(input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (m_busy && cnt < budget);
    chk("idle_timeout", 64'(m_busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; trigger = 1'b0; rdy = 1'b1; mode = 2'd0;
    pkt_len = 8'd8; num_pkts = 8'd1; gap_cycles = 8'd0;
    sel = 0; toggle = 1'b0; total = 0; passed = 0;
    popped = 0; stalls = 0; gap_run = 0; last_gap = 0;
    held_v = 1'b0; held_l = 1'b0; held_d = '0;

    @(negedge clk);
    chk("rst_v", 64'(m_v), 64'd0);
    chk("rst_l", 64'(m_l), 64'd0);
    chk("rst_d", 64'(m_d), 64'd0);
    chk("rst_busy", 64'(m_busy), 64'd0);
    chk("rst_ps", 64'(m_ps), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_v", 64'(m_v), 64'd0);

    // TABLE, 8 words back to back; inputs changed mid-run must not matter
    start(0, 2'd0, 8, 1, 0, 1'b0);
    pkt_len = 8'd2;
    num_pkts = 8'd5;
    wait_idle(50, n);
    chk("tbl_cycles", 64'(n), 64'd8);
    chk("tbl_ps", 64'(m_ps), 64'd1);
    chk("tbl_q", 64'(q.size()), 64'd0);

    // LFSR, two packets separated by a 5-cycle gap
    last_gap = 0;
    start(0, 2'd2, 3, 2, 5, 1'b0);
    wait_idle(100, n);
    chk("lfsr_gap", 64'(last_gap), 64'd5);
    chk("lfsr_cycles", 64'(n), 64'd11);
    chk("lfsr_ps", 64'(m_ps), 64'd3);
    chk("lfsr_q", 64'(q.size()), 64'd0);

    // second rise while busy is ignored
    start(0, 2'd1, 6, 1, 0, 1'b0);
    tick();
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    wait_idle(50, n);
    chk("busytrig_cycles", 64'(n), 64'd3);
    repeat (4) tick();
    chk("busytrig_v", 64'(m_v), 64'd0);
    chk("busytrig_ps", 64'(m_ps), 64'd4);
    chk("busytrig_q", 64'(q.size()), 64'd0);

    // zero length / zero count triggers are ignored
    pkt_len = 8'd0; num_pkts = 8'd1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    chk("len0_busy", 64'(m_busy), 64'd0);
    tick();
    chk("len0_v", 64'(m_v), 64'd0);
    pkt_len = 8'd4; num_pkts = 8'd0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    chk("cnt0_busy", 64'(m_busy), 64'd0);
    tick();
    chk("cnt0_v", 64'(m_v), 64'd0);
    chk("zero_ps", 64'(m_ps), 64'd4);

    // held-high trigger gives one run only
    start(0, 2'd3, 2, 1, 0, 1'b1);
    wait_idle(20, n);
    repeat (5) tick();
    trigger = 1'b0;
    repeat (3) tick();
    chk("hold_busy", 64'(m_busy), 64'd0);
    chk("hold_ps", 64'(m_ps), 64'd5);
    chk("hold_q", 64'(q.size()), 64'd0);

    // INCR wrap from FFFE with ready toggling
    stalls = 0;
    rdy = 1'b1;
    toggle = 1'b1;
    start(1, 2'd1, 4, 1, 0, 1'b0);
    wait_idle(50, n);
    toggle = 1'b0;
    rdy = 1'b1;
    tick();
    chk("incr_stalled", 64'(stalls > 0), 64'd1);
    chk("incr_q", 64'(q.size()), 64'd0);

    // CONST 1234
    start(2, 2'd3, 3, 1, 0, 1'b0);
    wait_idle(30, n);
    chk("const_q", 64'(q.size()), 64'd0);

    // asynchronous reset mid-packet
    popped = 0;
    start(0, 2'd0, 8, 1, 0, 1'b0);
    n = 0;
    while (popped < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_pops", 64'(popped), 64'd2);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_v", 64'(m_v), 64'd0);
    chk("arst_busy", 64'(m_busy), 64'd0);
    chk("arst_d", 64'(m_d), 64'd0);
    chk("arst_ps", 64'(m_ps), 64'd0);
    q.delete();
    held_v = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("relz_v", 64'(m_v), 64'd0);
    chk("relz_busy", 64'(m_busy), 64'd0);
    chk("relz_ps", 64'(m_ps), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
